// File: rtl/pipe_scoreboard.sv
// Purpose : hazard / forwarding scoreboard beside ID; tracks in-flight register writes by age and result latency.
// Latency : issue_ready and fwd_sel are combinational from the slot state and the issuing sources (0 cycles).
// Backpr. : issue_ready=0 stalls ID; a stalled instruction inserts a bubble and must be re-presented next cycle.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   issue_valid      ID presents an instruction this cycle
//   issue_we/rd/lat  destination write enable, register and forwardable latency of the issuing instruction
//   src_rd/src_used  PORTS packed source registers (port p at [p*AW +: AW]) and per-port read flags
//   flush            kill the issuing instruction and the current age-1 entry
//   issue_ready      instruction issues this cycle (0 = stall)
//   fwd_sel          per port: 0 = register file, k = forward from the producer at age k
//   inflight         valid bits of slots age 1..DEPTH (bit 0 = age 1)
module pipe_scoreboard #(
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int PORTS = 2,
    parameter int LW    = 2,
    parameter int SW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic                  issue_we,
    input  logic [AW-1:0]         issue_rd,
    input  logic [LW-1:0]         issue_lat,
    input  logic [PORTS*AW-1:0]   src_rd,
    input  logic [PORTS-1:0]      src_used,
    input  logic                  flush,
    output logic                  issue_ready,
    output logic [PORTS*SW-1:0]   fwd_sel,
    output logic [DEPTH-1:0]      inflight
);

    // Slot k holds the producer issued k cycles ago.
    logic [DEPTH:1]  slot_vld;
    logic [AW-1:0]   slot_rd  [1:DEPTH];
    logic [LW-1:0]   slot_lat [1:DEPTH];

    logic [LW-1:0]   lat_clip;
    logic [PORTS-1:0] hazard;
    logic            insert;

    // A zero latency still needs one stage; anything beyond the tracked depth
    // is forwardable from the oldest slot at the latest.
    always_comb begin
        lat_clip = issue_lat;
        if (issue_lat == '0) begin
            lat_clip = LW'(1);
        end else if (int'(issue_lat) > DEPTH) begin
            lat_clip = LW'(DEPTH);
        end
    end

    assign insert = issue_valid & issue_ready & issue_we & (issue_rd != '0) & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_vld <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                slot_rd[k]  <= '0;
                slot_lat[k] <= '0;
            end
        end else begin
            slot_vld[1] <= insert;
            slot_rd[1]  <= issue_rd;
            slot_lat[1] <= lat_clip;
            // Flush kills only the current age-1 entry, so it lands invalid in slot 2.
            for (int k = 2; k <= DEPTH; k++) begin
                slot_vld[k] <= (k == 2) ? (slot_vld[k-1] & ~flush) : slot_vld[k-1];
                slot_rd[k]  <= slot_rd[k-1];
                slot_lat[k] <= slot_lat[k-1];
            end
        end
    end

    // Scan oldest to youngest so the youngest matching producer overwrites
    // any older one; that is the value the instruction must see.
    always_comb begin
        hazard  = '0;
        fwd_sel = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (src_used[p] && (src_rd[p*AW +: AW] != '0)) begin
                for (int k = DEPTH; k >= 1; k--) begin
                    if (slot_vld[k] && (slot_rd[k] == src_rd[p*AW +: AW])) begin
                        fwd_sel[p*SW +: SW] = SW'(k);
                        hazard[p]           = (k < int'(slot_lat[k]));
                    end
                end
            end
        end
    end

    assign issue_ready = ~|hazard;
    assign inflight    = slot_vld;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Purpose : self-checking bench for pipe_scoreboard using a vector table plus hand-written reset sequence.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpr. : expected responses are queued when stimulus is driven and popped when the outputs are sampled.
module tb_pipe_scoreboard;

    logic       clk;
    logic       reset;
    logic       issue_valid;
    logic       issue_we;
    logic [4:0] issue_rd;
    logic [1:0] issue_lat;
    logic [9:0] src_rd;
    logic [1:0] src_used;
    logic       flush;
    logic       issue_ready;
    logic [3:0] fwd_sel;
    logic [2:0] inflight;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic       valid;
        logic       we;
        logic [4:0] rd;
        logic [1:0] lat;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] used;
        logic       fl;
        logic       rdy;
        logic [1:0] f0;
        logic [1:0] f1;
        logic [2:0] inf;
    } vec_t;

    typedef struct {
        int         idx;
        logic       rdy;
        logic [1:0] f0;
        logic [1:0] f1;
        logic [2:0] inf;
    } exp_t;

    vec_t tbl [21];
    exp_t exp_q [$];

    pipe_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_rd    (issue_rd),
        .issue_lat   (issue_lat),
        .src_rd      (src_rd),
        .src_used    (src_used),
        .flush       (flush),
        .issue_ready (issue_ready),
        .fwd_sel     (fwd_sel),
        .inflight    (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int idx);
        exp_t e;
        issue_valid = v.valid;
        issue_we    = v.we;
        issue_rd    = v.rd;
        issue_lat   = v.lat;
        src_rd      = {v.s1, v.s0};
        src_used    = v.used;
        flush       = v.fl;
        e.idx = idx;
        e.rdy = v.rdy;
        e.f0  = v.f0;
        e.f1  = v.f1;
        e.inf = v.inf;
        exp_q.push_back(e);
    endtask

    task automatic sample_pop();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL queue: empty at sample time, expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            chk("ready",    e.idx, 32'(issue_ready),  32'(e.rdy));
            chk("fwd0",     e.idx, 32'(fwd_sel[1:0]), 32'(e.f0));
            chk("fwd1",     e.idx, 32'(fwd_sel[3:2]), 32'(e.f1));
            chk("inflight", e.idx, 32'(inflight),     32'(e.inf));
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        drive(v, idx);
        sample_pop();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_inflight"}, 0, 32'(inflight),    32'd0);
        chk({name, "_ready"},    0, 32'(issue_ready), 32'd1);
        chk({name, "_fwd"},      0, 32'(fwd_sel),     32'd0);
    endtask

    initial begin
        vec_t v;
        pass_cnt  = 0;
        total_cnt = 0;

        //            vld we  rd  lat s0  s1  used fl   rdy f0 f1 inf
        tbl[0]  = '{1'b1, 1'b1, 5'd5,  2'd1, 5'd0, 5'd0,  2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 3'b000}; // ALU rd5
        tbl[1]  = '{1'b1, 1'b0, 5'd0,  2'd1, 5'd5, 5'd0,  2'b01, 1'b0, 1'b1, 2'd1, 2'd0, 3'b001}; // back-to-back
        tbl[2]  = '{1'b1, 1'b0, 5'd0,  2'd1, 5'd5, 5'd0,  2'b01, 1'b0, 1'b1, 2'd2, 2'd0, 3'b010}; // one later
        tbl[3]  = '{1'b1, 1'b1, 5'd8,  2'd2, 5'd0, 5'd0,  2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 3'b100}; // load rd8
        tbl[4]  = '{1'b1, 1'b1, 5'd11, 2'd1, 5'd0, 5'd8,  2'b10, 1'b0, 1'b0, 2'd0, 2'd1, 3'b001}; // load-use stall
        tbl[5]  = '{1'b1, 1'b1, 5'd11, 2'd1, 5'd0, 5'd8,  2'b10, 1'b0, 1'b1, 2'd0, 2'd2, 3'b010}; // reissue
        tbl[6]  = '{1'b1, 1'b1, 5'd8,  2'd2, 5'd0, 5'd0,  2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 3'b101}; // load rd8 again
        tbl[7]  = '{1'b1, 1'b1, 5'd0,  2'd2, 5'd0, 5'd8,  2'b01, 1'b0, 1'b1, 2'd0, 2'd0, 3'b011}; // rd0, unused src1
        tbl[8]  = '{1'b0, 1'b0, 5'd0,  2'd0, 5'd0, 5'd0,  2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 3'b110}; // rd0 not inserted
        tbl[9]  = '{1'b1, 1'b1, 5'd3,  2'd1, 5'd0, 5'd0,  2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 3'b100}; // rd3 lat1
        tbl[10] = '{1'b1, 1'b1, 5'd3,  2'd2, 5'd0, 5'd0,  2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 3'b001}; // rd3 lat2
        tbl[11] = '{1'b1, 1'b0, 5'd0,  2'd1, 5'd3, 5'd0,  2'b01, 1'b0, 1'b0, 2'd1, 2'd0, 3'b011}; // youngest stalls
        tbl[12] = '{1'b1, 1'b0, 5'd0,  2'd1, 5'd3, 5'd0,  2'b01, 1'b0, 1'b1, 2'd2, 2'd0, 3'b110}; // age 2, not 3
        tbl[13] = '{1'b1, 1'b1, 5'd9,  2'd2, 5'd0, 5'd0,  2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 3'b100}; // load rd9
        tbl[14] = '{1'b1, 1'b1, 5'd10, 2'd1, 5'd0, 5'd0,  2'b00, 1'b1, 1'b1, 2'd0, 2'd0, 3'b001}; // flush, rd10
        tbl[15] = '{1'b1, 1'b0, 5'd0,  2'd1, 5'd9, 5'd10, 2'b11, 1'b0, 1'b1, 2'd0, 2'd0, 3'b000}; // both gone
        tbl[16] = '{1'b1, 1'b1, 5'd4,  2'd0, 5'd0, 5'd0,  2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 3'b000}; // lat0 -> 1
        tbl[17] = '{1'b1, 1'b1, 5'd6,  2'd3, 5'd4, 5'd0,  2'b01, 1'b0, 1'b1, 2'd1, 2'd0, 3'b001}; // no stall on rd4
        tbl[18] = '{1'b1, 1'b0, 5'd0,  2'd1, 5'd6, 5'd0,  2'b01, 1'b0, 1'b0, 2'd1, 2'd0, 3'b011}; // lat3 stall 1
        tbl[19] = '{1'b1, 1'b0, 5'd0,  2'd1, 5'd6, 5'd0,  2'b01, 1'b0, 1'b0, 2'd2, 2'd0, 3'b110}; // lat3 stall 2
        tbl[20] = '{1'b1, 1'b0, 5'd0,  2'd1, 5'd6, 5'd0,  2'b01, 1'b0, 1'b1, 2'd3, 2'd0, 3'b100}; // age 3 forward

        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rd    = '0;
        issue_lat   = '0;
        src_rd      = '0;
        src_used    = '0;
        flush       = 1'b0;

        @(negedge clk);
        chk_idle("rst_hold");
        reset = 1'b0;
        @(negedge clk);
        chk_idle("rst_rel");
        @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i], i);
        end

        // Fill all three slots, then reset asynchronously in mid-cycle.
        v = '{1'b1, 1'b1, 5'd1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 3'b000};
        step(v, 100);
        v = '{1'b1, 1'b1, 5'd2, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 3'b001};
        step(v, 101);
        v = '{1'b1, 1'b1, 5'd3, 2'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 3'b011};
        step(v, 102);
        v = '{1'b1, 1'b0, 5'd0, 2'd1, 5'd3, 5'd2, 2'b11, 1'b0, 1'b0, 2'd1, 2'd2, 3'b111};
        drive(v, 103);
        sample_pop();
        #1;
        reset = 1'b1;
        #1;
        chk_idle("rst_async");
        @(posedge clk);
        #1;
        chk_idle("rst_edge");
        reset = 1'b0;
        #1;
        chk_idle("rst_after");
        @(negedge clk);
        chk_idle("rst_settle");

        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
